memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 106 ++++++++++
 tb/tb_memory_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// MEM stage of a 5-stage pipeline: issues data-memory requests, stalls the
// front of the pipe while a store waits for grant or a load waits for its
// read data, and owns the MEM/WB pipeline register.
module memory_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // EX/MEM
  input  logic [DATA_WIDTH-1:0] i_alu_result_m,
  input  logic [DATA_WIDTH-1:0] i_write_data_m,
  input  logic                  i_regwrite_m,
  input  logic                  i_memwrite_m,
  input  logic [1:0]            i_resultsrc_m,
  input  logic [4:0]            i_rd_addr_m,
  input  logic [ADDR_WIDTH-1:0] i_pc4_m,
  // data memory
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  // hazard / forwarding
  output logic                  o_stall_m,
  output logic [DATA_WIDTH-1:0] o_forward_m,
  // MEM/WB
  output logic                  o_regwrite_w,
  output logic [1:0]            o_resultsrc_w,
  output logic [DATA_WIDTH-1:0] o_alu_result_w,
  output logic [DATA_WIDTH-1:0] o_read_data_w,
  output logic [4:0]            o_rd_addr_w,
  output logic [ADDR_WIDTH-1:0] o_pc4_w
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] WAIT_RD = 1'b1;

  logic [0:0] state, state_nxt;
  logic       access, is_load, rd_done;

  // A store takes priority if both store and load encodings are present.
  assign access  = i_memwrite_m | (i_resultsrc_m == 2'b01);
  assign is_load = access & ~i_memwrite_m;
  // rvalid only means something while a load is outstanding.
  assign rd_done = (state == WAIT_RD) & i_dmem_rvalid;

  assign o_dmem_req   = (state == IDLE) & access;
  assign o_dmem_we    = i_memwrite_m;
  assign o_dmem_addr  = {i_alu_result_m[DATA_WIDTH-1:2], 2'b00};
  assign o_dmem_wdata = i_write_data_m;
  assign o_forward_m  = i_alu_result_m;

  // Hold the pipe until a store is granted or a load's data has returned.
  always_comb begin
    o_stall_m = 1'b0;
    if (state == IDLE)
      o_stall_m = access & ~(i_memwrite_m & i_dmem_gnt);
    else
      o_stall_m = ~i_dmem_rvalid;
  end

  // Next-state: a granted load waits for rvalid; grant in WAIT_RD is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_load && i_dmem_gnt) state_nxt = WAIT_RD;
      WAIT_RD: if (i_dmem_rvalid)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding load.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // MEM/WB register: advance when not stalled, otherwise insert a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_regwrite_w   <= 1'b0;
      o_resultsrc_w  <= '0;
      o_alu_result_w <= '0;
      o_rd_addr_w    <= '0;
      o_pc4_w        <= '0;
    end else if (!o_stall_m) begin
      o_regwrite_w   <= i_regwrite_m;
      o_resultsrc_w  <= i_resultsrc_m;
      o_alu_result_w <= i_alu_result_m;
      o_rd_addr_w    <= i_rd_addr_m;
      o_pc4_w        <= i_pc4_m;
    end else begin
      o_regwrite_w   <= 1'b0;
    end
  end

  // Load data is captured only on an accepted read response.
  always_ff @(posedge i_clk) begin
    if (i_rst)        o_read_data_w <= '0;
    else if (rd_done) o_read_data_w <= i_dmem_rdata;
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, stores with and without
// immediate grant, loads with grant/rvalid delays, spurious rvalid, reset mid-load.
module tb_memory_stage;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] alu, wdata, rdata;
  logic          regwrite, memwrite, gnt, rvalid;
  logic [1:0]    resultsrc;
  logic [4:0]    rd;
  logic [AW-1:0] pc4;
  logic          req, we, stall, regwrite_w;
  logic [DW-1:0] addr, dwdata, fwd, alu_w, rdata_w;
  logic [1:0]    resultsrc_w;
  logic [4:0]    rd_w;
  logic [AW-1:0] pc4_w;

  int total = 0;
  int bad   = 0;
  int stall_cnt;

  memory_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_result_m(alu), .i_write_data_m(wdata),
    .i_regwrite_m(regwrite), .i_memwrite_m(memwrite),
    .i_resultsrc_m(resultsrc), .i_rd_addr_m(rd), .i_pc4_m(pc4),
    .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr), .o_dmem_wdata(dwdata),
    .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
    .o_stall_m(stall), .o_forward_m(fwd),
    .o_regwrite_w(regwrite_w), .o_resultsrc_w(resultsrc_w),
    .o_alu_result_w(alu_w), .o_read_data_w(rdata_w),
    .o_rd_addr_w(rd_w), .o_pc4_w(pc4_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; sample 1 time unit after the edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [DW-1:0] a, input logic [DW-1:0] wd,
                           input logic rw, input logic mw, input logic [1:0] rs,
                           input logic [4:0] r, input logic [AW-1:0] p);
    alu = a; wdata = wd; regwrite = rw; memwrite = mw; resultsrc = rs; rd = r; pc4 = p;
  endtask

  initial begin
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    set_instr('0, '0, 1'b0, 1'b0, 2'b00, 5'd0, '0);
    step(); step();
    // reset state
    chk("rst_regwrite_w", regwrite_w, 0);
    chk("rst_alu_w", alu_w, 0);
    chk("rst_rdata_w", rdata_w, 0);
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;

    // ALU op: no access, 1-cycle latency
    set_instr(32'h10, '0, 1'b1, 1'b0, 2'b00, 5'd5, 10'h14);
    #1;
    chk("add_stall", stall, 0);
    chk("add_req", req, 0);
    chk("add_fwd", fwd, 32'h10);
    step();
    chk("add_regwrite_w", regwrite_w, 1);
    chk("add_rd_w", rd_w, 5);
    chk("add_alu_w", alu_w, 32'h10);
    chk("add_pc4_w", pc4_w, 10'h14);

    // store, granted same cycle
    set_instr(32'h103, 32'hDEADBEEF, 1'b0, 1'b1, 2'b00, 5'd0, 10'h18);
    gnt = 1'b1; #1;
    chk("st_req", req, 1);
    chk("st_we", we, 1);
    chk("st_addr", addr, 32'h100);
    chk("st_wdata", dwdata, 32'hDEADBEEF);
    chk("st_stall", stall, 0);
    step();
    chk("st_regwrite_w", regwrite_w, 0);
    chk("st_alu_w", alu_w, 32'h103);

    // store waiting one cycle for grant: bubble holds fields
    set_instr(32'h204, 32'h11, 1'b0, 1'b1, 2'b00, 5'd0, 10'h1c);
    gnt = 1'b0; #1;
    chk("stw_stall", stall, 1);
    chk("stw_req", req, 1);
    step();
    chk("stw_alu_held", alu_w, 32'h103);
    gnt = 1'b1; #1;
    chk("stw_stall_gnt", stall, 0);
    step();
    chk("stw_alu_w", alu_w, 32'h204);
    gnt = 1'b0;

    // load: 2 cycles no grant, grant, 2 cycles wait (grant ignored), rvalid
    set_instr(32'h200, '0, 1'b1, 1'b0, 2'b01, 5'd7, 10'h30);
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      gnt    = (c == 2) || (c == 4);
      rvalid = (c == 5);
      rdata  = (c == 5) ? 32'hCAFEF00D : 32'h0;
      #1;
      if (stall) stall_cnt++;
      if (c == 0) chk("ld_req_idle", req, 1);
      if (c == 0) chk("ld_we", we, 0);
      if (c == 3) chk("ld_req_wait", req, 0);
      step();
      if (c < 5) chk("ld_bubble", regwrite_w, 0);
    end
    gnt = 1'b0; rvalid = 1'b0;
    chk("ld_stall_cycles", stall_cnt, 5);
    chk("ld_rdata_w", rdata_w, 32'hCAFEF00D);
    chk("ld_regwrite_w", regwrite_w, 1);
    chk("ld_rd_w", rd_w, 7);
    chk("ld_resultsrc_w", resultsrc_w, 1);

    // spurious rvalid while idle with a non-memory op
    set_instr(32'h55, '0, 1'b1, 1'b0, 2'b00, 5'd3, 10'h34);
    rvalid = 1'b1; rdata = 32'h1234; #1;
    chk("sp_stall", stall, 0);
    step();
    rvalid = 1'b0;
    chk("sp_rdata_w", rdata_w, 32'hCAFEF00D);
    chk("sp_rd_w", rd_w, 3);

    // fastest load: grant then rvalid next cycle
    set_instr(32'h40, '0, 1'b1, 1'b0, 2'b01, 5'd9, 10'h38);
    gnt = 1'b1; step(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h0000_ABCD; #1;
    chk("fl_stall", stall, 0);
    step();
    rvalid = 1'b0;
    chk("fl_rdata_w", rdata_w, 32'h0000_ABCD);
    chk("fl_rd_w", rd_w, 9);

    // reset in WAIT_RD abandons the load
    set_instr(32'h300, '0, 1'b1, 1'b0, 2'b01, 5'd4, 10'h3c);
    gnt = 1'b1; step(); gnt = 1'b0; #1;
    chk("rl_wait_stall", stall, 1);
    rst = 1'b1;
    set_instr('0, '0, 1'b0, 1'b0, 2'b00, 5'd0, '0);
    step();
    chk("rl_req", req, 0);
    chk("rl_stall", stall, 0);
    chk("rl_rdata_w", rdata_w, 0);
    chk("rl_rd_w", rd_w, 0);
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'hBAD0BAD0; #1;
    chk("rl_post_stall", stall, 0);
    step();
    rvalid = 1'b0;
    chk("rl_no_capture", rdata_w, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
